// File: rtl/processador_multiciclo_if.sv
// Instruction/status bundle between the sequencer (master) and the multi-cycle core (slave).
interface processador_multiciclo_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       iin;
    logic              run;
    logic [DATA_W-1:0] bus;
    logic              busy;
    logic              done;
    logic [2:0]        flags;

    modport master (output iin, run, input bus, busy, done, flags);
    modport slave  (input iin, run, output bus, busy, done, flags);
endinterface

// File: rtl/processador_multiciclo.sv
// Parametrised multi-cycle register-file core: one instruction per run handshake,
// 1-cycle moves and 3-cycle ALU ops sharing a single registered bus.
module processador_multiciclo #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    processador_multiciclo_if.slave cpu
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] a_q, g_q, bus_q;
    logic              busy_q, done_q;
    logic [2:0]        flags_q;

    // Fixed 8-entry read view so out-of-range indices read as zero
    logic [7:0][DATA_W-1:0] rv;
    for (genvar i = 0; i < 8; i++) begin : g_rv
        if (i < NREGS) begin : g_on
            assign rv[i] = regs[i];
        end else begin : g_off
            assign rv[i] = '0;
        end
    end

    logic [2:0] op, rx, ry, i_op, i_rx, i_ry;
    logic [3:0] sh;
    assign op   = ir[15:13];
    assign rx   = ir[12:10];
    assign ry   = ir[9:7];
    assign sh   = ir[3:0];
    assign i_op = cpu.iin[15:13];
    assign i_rx = cpu.iin[12:10];
    assign i_ry = cpu.iin[9:7];

    logic [DATA_W+9:0] imm_w;
    logic [DATA_W-1:0] immx;
    assign imm_w = {{DATA_W{1'b0}}, cpu.iin[9:0]};
    assign immx  = imm_w[DATA_W-1:0];

    function automatic logic is_alu(input logic [2:0] o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_SHL);
    endfunction

    logic [DATA_W-1:0]  b, g_n;
    logic               c_n;
    logic [DATA_W+15:0] wide;

    always_comb begin
        b    = rv[ry];
        g_n  = '0;
        c_n  = 1'b0;
        wide = '0;
        case (op)
            OP_ADD: {c_n, g_n} = {1'b0, a_q} + {1'b0, b};
            OP_SUB: {c_n, g_n} = {1'b0, a_q} + {1'b0, ~b} + (DATA_W+1)'(1);
            OP_AND: g_n = a_q & b;
            OP_SHL: begin
                // Upper half collects everything shifted past the MSB
                wide = {16'b0, a_q} << sh;
                g_n  = wide[DATA_W-1:0];
                c_n  = |wide[DATA_W+15:DATA_W];
            end
            default: ;
        endcase
    end

    logic              we;
    logic [DATA_W-1:0] wd;
    always_comb begin
        we = 1'b0;
        wd = bus_q;
        if (state == T1)
            we = (op == OP_MV) || (op == OP_MVI) || (op == OP_MVNZ && !flags_q[1]);
        else if (state == T3) begin
            we = 1'b1;
            wd = g_q;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            ir      <= '0;
            a_q     <= '0;
            g_q     <= '0;
            bus_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flags_q <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (we)
                for (int i = 0; i < NREGS; i++)
                    if (rx == 3'(i)) regs[i] <= wd;
            case (state)
                IDLE: if (cpu.run) begin
                    ir     <= cpu.iin;
                    state  <= T1;
                    busy_q <= 1'b1;
                    done_q <= !is_alu(i_op);
                    case (i_op)
                        OP_MV, OP_MVNZ: bus_q <= rv[i_ry];
                        OP_MVI:         bus_q <= immx;
                        3'b111:         bus_q <= '0;
                        default:        bus_q <= rv[i_rx];
                    endcase
                end
                T1: if (is_alu(op)) begin
                    a_q   <= bus_q;
                    bus_q <= rv[ry];
                    state <= T2;
                end else begin
                    state  <= IDLE;
                    bus_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                T2: begin
                    g_q     <= g_n;
                    flags_q <= {g_n[DATA_W-1], g_n == '0, c_n};
                    bus_q   <= g_n;
                    done_q  <= 1'b1;
                    state   <= T3;
                end
                default: begin
                    state  <= IDLE;
                    bus_q  <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.bus   = bus_q;
    assign cpu.busy  = busy_q;
    assign cpu.done  = done_q;
    assign cpu.flags = flags_q;
endmodule

// File: tb/tb_processador_multiciclo.sv
// Directed bench for processador_multiciclo: table of instructions with expected
// per-cycle bus/done values, plus hand sequences for reset, ignored run and NREGS=4.
module tb_processador_multiciclo;
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    processador_multiciclo_if #(.DATA_W(16)) ia ();
    processador_multiciclo_if #(.DATA_W(16)) ib ();

    processador_multiciclo #(.DATA_W(16), .NREGS(8)) dut8 (
        .clock(clock), .resetn(resetn), .cpu(ia.slave));
    processador_multiciclo #(.DATA_W(16), .NREGS(4)) dut4 (
        .clock(clock), .resetn(resetn), .cpu(ib.slave));

    int   total = 0;
    int   bad   = 0;
    logic sel   = 1'b0;

    logic [15:0] o_bus;
    logic        o_busy, o_done;
    logic [2:0]  o_flags;
    assign o_bus   = sel ? ib.bus   : ia.bus;
    assign o_busy  = sel ? ib.busy  : ia.busy;
    assign o_done  = sel ? ib.done  : ia.done;
    assign o_flags = sel ? ib.flags : ia.flags;

    typedef struct {
        logic [15:0] instr;
        int          n;
        logic [15:0] b0, b1, b2;
        logic [2:0]  fl;
    } vec_t;

    vec_t tv [21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic r);
        if (sel) begin ib.iin = i; ib.run = r; end
        else     begin ia.iin = i; ia.run = r; end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Called #1 after a rising edge with the core idle
    task automatic exec(input vec_t v, input string nm);
        logic [15:0] eb;
        drive(v.instr, 1'b1);
        cyc();
        drive(v.instr, 1'b0);
        for (int c = 0; c < v.n; c++) begin
            eb = (c == 0) ? v.b0 : (c == 1) ? v.b1 : v.b2;
            chk($sformatf("%s.busy%0d", nm, c), 32'(o_busy), 32'd1);
            chk($sformatf("%s.done%0d", nm, c), 32'(o_done), 32'(c == v.n - 1));
            chk($sformatf("%s.bus%0d", nm, c), 32'(o_bus), 32'(eb));
            if (c == 2) chk($sformatf("%s.flagsT3", nm), 32'(o_flags), 32'(v.fl));
            cyc();
        end
        chk($sformatf("%s.idle_busy", nm), 32'(o_busy), 32'd0);
        chk($sformatf("%s.idle_done", nm), 32'(o_done), 32'd0);
        chk($sformatf("%s.idle_bus", nm), 32'(o_bus), 32'd0);
        chk($sformatf("%s.flags", nm), 32'(o_flags), 32'(v.fl));
    endtask

    initial begin
        tv[0]  = '{16'h2001, 1, 16'h0001, 16'h0000, 16'h0000, 3'b000};
        tv[1]  = '{16'h2402, 1, 16'h0002, 16'h0000, 16'h0000, 3'b000};
        tv[2]  = '{16'h4080, 3, 16'h0001, 16'h0002, 16'h0003, 3'b000};
        tv[3]  = '{16'h0000, 1, 16'h0003, 16'h0000, 16'h0000, 3'b000};
        tv[4]  = '{16'h2403, 1, 16'h0003, 16'h0000, 16'h0000, 3'b000};
        tv[5]  = '{16'h6080, 3, 16'h0003, 16'h0003, 16'h0000, 3'b011};
        tv[6]  = '{16'hC880, 1, 16'h0003, 16'h0000, 16'h0000, 3'b011};
        tv[7]  = '{16'h0900, 1, 16'h0000, 16'h0000, 16'h0000, 3'b011};
        tv[8]  = '{16'h23FF, 1, 16'h03FF, 16'h0000, 16'h0000, 3'b011};
        tv[9]  = '{16'hA006, 3, 16'h03FF, 16'h03FF, 16'hFFC0, 3'b100};
        tv[10] = '{16'h2440, 1, 16'h0040, 16'h0000, 16'h0000, 3'b100};
        tv[11] = '{16'h4080, 3, 16'hFFC0, 16'h0040, 16'h0000, 3'b011};
        tv[12] = '{16'h2FFF, 1, 16'h03FF, 16'h0000, 16'h0000, 3'b011};
        tv[13] = '{16'hAC08, 3, 16'h03FF, 16'h0000, 16'hFF00, 3'b101};
        tv[14] = '{16'h8C80, 3, 16'hFF00, 16'h0040, 16'h0000, 3'b010};
        tv[15] = '{16'hE000, 1, 16'h0000, 16'h0000, 16'h0000, 3'b010};
        tv[16] = '{16'hA400, 3, 16'h0040, 16'h0000, 16'h0040, 3'b000};
        tv[17] = '{16'hC880, 1, 16'h0040, 16'h0000, 16'h0000, 3'b000};
        tv[18] = '{16'h0900, 1, 16'h0040, 16'h0000, 16'h0000, 3'b000};
        tv[19] = '{16'h6080, 3, 16'h0000, 16'h0040, 16'hFFC0, 3'b100};
        tv[20] = '{16'h2005, 1, 16'h0005, 16'h0000, 16'h0000, 3'b100};

        resetn = 1'b0;
        ia.iin = '0; ia.run = 1'b0;
        ib.iin = '0; ib.run = 1'b0;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            chk($sformatf("rst%0d.busy", s), 32'(o_busy), 32'd0);
            chk($sformatf("rst%0d.done", s), 32'(o_done), 32'd0);
            chk($sformatf("rst%0d.bus", s), 32'(o_bus), 32'd0);
            chk($sformatf("rst%0d.flags", s), 32'(o_flags), 32'd0);
        end
        sel = 1'b0;
        resetn = 1'b1;
        cyc();

        for (int i = 0; i < 21; i++) exec(tv[i], $sformatf("v%0d", i));

        // run during T1 of an add must not queue the held instruction
        drive(16'h4000, 1'b1);
        cyc();
        chk("ign.t1bus", 32'(o_bus), 32'h0005);
        drive(16'h2009, 1'b1);
        cyc();
        drive(16'h2009, 1'b0);
        chk("ign.t2bus", 32'(o_bus), 32'h0005);
        cyc();
        chk("ign.t3bus", 32'(o_bus), 32'h000A);
        chk("ign.t3done", 32'(o_done), 32'd1);
        cyc();
        chk("ign.idle", 32'(o_busy), 32'd0);
        exec('{16'h0000, 1, 16'h000A, 16'h0000, 16'h0000, 3'b000}, "ign.rd");

        // reset during T2, run held high through release
        drive(16'h4000, 1'b1);
        cyc();
        drive(16'h4000, 1'b0);
        cyc();
        chk("rmid.t2bus", 32'(o_bus), 32'h000A);
        resetn = 1'b0;
        #1;
        chk("rmid.busy", 32'(o_busy), 32'd0);
        chk("rmid.done", 32'(o_done), 32'd0);
        chk("rmid.bus", 32'(o_bus), 32'd0);
        chk("rmid.flags", 32'(o_flags), 32'd0);
        drive(16'h0480, 1'b1);
        #2;
        resetn = 1'b1;
        cyc();
        chk("rmid.acc_busy", 32'(o_busy), 32'd1);
        chk("rmid.acc_done", 32'(o_done), 32'd1);
        chk("rmid.acc_bus", 32'(o_bus), 32'd0);
        drive(16'h0480, 1'b0);
        cyc();
        chk("rmid.after", 32'(o_busy), 32'd0);
        exec('{16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 3'b000}, "rmid.r0");

        // NREGS=4 instance: r5 is out of range
        sel = 1'b1;
        #0;
        exec('{16'h3407, 1, 16'h0007, 16'h0000, 16'h0000, 3'b000}, "n4.mvi_r5");
        exec('{16'h0080, 1, 16'h0000, 16'h0000, 16'h0000, 3'b000}, "n4.mv_r0_r1");
        exec('{16'h0280, 1, 16'h0000, 16'h0000, 16'h0000, 3'b000}, "n4.mv_r0_r5");
        exec('{16'h2C09, 1, 16'h0009, 16'h0000, 16'h0000, 3'b000}, "n4.mvi_r3");
        exec('{16'h0180, 1, 16'h0009, 16'h0000, 16'h0000, 3'b000}, "n4.mv_r0_r3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
